alu_seq_ctrl: RTL



---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_op_decode.sv | 29 ++
 rtl/alu_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: ALU ops,
// opcodes, operand/result mux selects and the sequencer state enum.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SRA = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_MEM      = 2'b01;
  localparam logic [1:0] RES_ALU_LIVE = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// funct3/funct7b5 to ALU operation for R- and I-type arithmetic; flags the
// unsupported xor encoding.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_r,
  output logic [2:0] alu_control,
  output logic       illegal_op
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal_op  = 1'b0;
    case (funct3)
      3'b000: alu_control = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLT;
      3'b100: illegal_op  = 1'b1;
      3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multicycle RV32I control sequencer driving the ALU and datapath muxes.
// Define ALU_SEQ_CTRL_PERF_EN to add the retired-instruction counter output.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch_taken,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       illegal
`ifdef ALU_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic [2:0]       dec_alu;
  logic             dec_ill;
  logic             in_req;

  alu_op_decode u_dec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_r        (state_q == S_EXEC_R),
    .alu_control (dec_alu),
    .illegal_op  (dec_ill)
  );

  assign in_req = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                  (state_q == S_MEMWRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
                  else if (cnt_q == WAIT_LAST) state_d = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
                  else if (cnt_q == WAIT_LAST) state_d = S_TRAP;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
                  else if (cnt_q == WAIT_LAST) state_d = S_TRAP;
      S_EXEC_R, S_EXEC_I: state_d = dec_ill ? S_TRAP : S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_FETCH : S_TRAP;
      S_JAL:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase

    // Every entry into a request state is a state change, so clearing on
    // change covers "cleared on entering".
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (in_req && !mem_ready) cnt_d = cnt_q + CNT_W'(1);

    illegal_d = illegal_q || (state_d == S_TRAP);
  end

  // Gating on rst_n makes mem_req drop the instant reset asserts, even though
  // the reset state is FETCH.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    reg_write    = 1'b0;
    alu_control  = ALU_ADD;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    result_src   = RES_ALUOUT;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            result_src = RES_ALU_LIVE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: mem_req = 1'b1;
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = RES_MEM;
        end
        S_MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a   = SRCA_RS1;
          alu_control = dec_alu;
        end
        S_EXEC_I: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          alu_control = dec_alu;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = SRCA_RS1;
          alu_control = ALU_SUB;
          if (funct3 == 3'b000)      branch_taken = zero;
          else if (funct3 == 3'b001) branch_taken = !zero;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;

`ifdef ALU_SEQ_CTRL_PERF_EN
  logic [31:0] instret_q, instret_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  always_comb begin
    instret_d = instret_q;
    if (state_d == S_FETCH &&
        (state_q == S_MEMWB || state_q == S_MEMWRITE || state_q == S_ALUWB ||
         state_q == S_BRANCH || state_q == S_JAL))
      instret_d = instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

endmodule
